// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between the UART receive FIFO (master) and the core (slave).
interface uart_rx_fifo_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;

    modport master (output rdata, output rvalid, input rready);
    modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a first-word-fall-through byte FIFO.
// Sticky ferr/ovf (and perr with parity) flags are cleared by clr; a set in the same cycle wins.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | timing to mid start bit; a high sample there is a false start
// DATA   | sampling 8 data bits LSB first, one per CLKS_PER_BIT
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then push or flag the byte
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rxd,
    uart_rx_fifo_if.master   rx_bus,
    output logic [FIFO_AW:0] count,
    output logic             ferr,
    output logic             ovf,
`ifdef UART_RX_PARITY_EN
    output logic             perr,
`endif
    input  logic             clr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0]   HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         bi, bi_n;
    logic [7:0]         shreg, shreg_n;
    logic               rx_m, rx_s, rx_prev;
    logic               push, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic               par_bit, par_bit_n;
    logic               perr_set;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               full, pop, wr_en, ovf_set;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rxd;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bi      <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bi      <= bi_n;
            shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bi_n      = bi;
        shreg_n   = shreg;
        push      = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
        perr_set  = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end else begin
                        bi_n    = '0;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n         = '0;
                    shreg_n[bi]   = rx_s;
                    bi_n          = bi + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bi == 3'd7) state_n = S_PARITY;
`else
                    if (bi == 3'd7) state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_M1) begin
                    cnt_n     = '0;
                    par_bit_n = rx_s;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    // A bad stop bit takes precedence; a good one still needs even parity.
                    if (!rx_s) ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (^{shreg, par_bit}) perr_set = 1'b1;
`endif
                    else push = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign rx_bus.rvalid = (count != '0);
    assign rx_bus.rdata  = rx_bus.rvalid ? mem[rd_ptr] : 8'h00;
    assign full          = (count == FULL_CNT);
    assign pop           = rx_bus.rvalid && rx_bus.rready;
    // When full, a simultaneous pop frees the slot the push needs.
    assign wr_en         = push && (!full || pop);
    assign ovf_set       = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ferr <= 1'b0;
            ovf  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr <= 1'b0;
`endif
        end else begin
            if (ferr_set)  ferr <= 1'b1;
            else if (clr)  ferr <= 1'b0;
            if (ovf_set)   ovf  <= 1'b1;
            else if (clr)  ovf  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (perr_set)  perr <= 1'b1;
            else if (clr)  perr <= 1'b0;
`endif
        end
    end

endmodule
